decode_extend_pipe: RTL and testbench

//  Parametrised, elastic ID-stage helper for the MIPS pipeline. Splits a 32-bit instruction into
//  its fields and extends the immediate in a selectable mode. Computes branch/jump targets and
//  the rs/rt equality flag, then carries the result through STAGES registered slots.

---
 rtl/decode_pkg.sv | 40 ++++
 rtl/decode_pipe_slot.sv | 30 +++
 rtl/decode_extend_pipe.sv | 122 ++++++++++++
 tb/tb_decode_extend_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode constants for the MIPS ID-stage helpers: opcodes, function codes,
// instruction-field layout and immediate-extension modes.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  localparam int INSTR_W  = 32;
  localparam int FIELDS_W = 32;
  localparam int IMM_W    = 16;
  localparam int JIDX_W   = 26;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10
  } ext_mode_e;

  // Field order matches the instruction word, so a cast splits it directly.
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_fields_t;

endpackage

// File: rtl/decode_pipe_slot.sv
// One elastic register slot of decode_extend_pipe: a valid bit plus a payload that
// loads whenever the top marks the slot as empty or draining this cycle.
module decode_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // NOTE: state uses non-blocking (<=) so each slot captures its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      // NOTE: payload is reset so outputs read 0 after reset; flush only drops valid bits.
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/decode_extend_pipe.sv
// Elastic ID-stage decode/extend pipeline with STAGES valid/ready slots.
// Branch/jump targets and rs==rt compare exist only when DECODE_BRANCH_EN is defined.
module decode_extend_pipe #(
  parameter int STAGES = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [1:0]        ext_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [DATA_W-1:0] imm_ext,
  output logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] j_target,
  output logic              equal
);
  import decode_pkg::*;

  instr_fields_t     fields;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_ext_c;

  assign fields = instr_fields_t'(instr);
  assign imm    = instr[IMM_W-1:0];

  // NOTE: every variable in a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    imm_ext_c = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    case (ext_mode)
      EXT_ZERO:  imm_ext_c = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_UPPER: imm_ext_c = {imm, {(DATA_W-IMM_W){1'b0}}};
      default:   ;
    endcase
  end

`ifdef DECODE_BRANCH_EN
  localparam int PW = FIELDS_W + DATA_W + 2*ADDR_W + 1;
  logic [ADDR_W-1:0] br_c;
  logic [ADDR_W-1:0] j_c;
  logic [PW-1:0]     in_pay;
  logic [PW-1:0]     out_pay;

  // Sign-extended word offset; bits shifted past ADDR_W are simply dropped.
  assign br_c = pc_plus4 + {{(ADDR_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};

  if (ADDR_W > JIDX_W + 2) begin : g_jseg
    assign j_c = {pc_plus4[ADDR_W-1:JIDX_W+2], instr[JIDX_W-1:0], 2'b00};
  end else begin : g_jflat
    assign j_c = {instr[JIDX_W-1:0], 2'b00};
  end

  assign in_pay = {fields, imm_ext_c, br_c, j_c, rs_data == rt_data};
`else
  localparam int PW = FIELDS_W + DATA_W;
  logic [PW-1:0] in_pay;
  logic [PW-1:0] out_pay;
  logic          unused_branch;

  assign in_pay        = {fields, imm_ext_c};
  assign unused_branch = ^{pc_plus4, rs_data, rt_data};
`endif

  logic [STAGES:0]         v;
  logic [STAGES:0]         rdy;
  logic [STAGES:0][PW-1:0] d;

  assign v[0] = in_valid;
  assign d[0] = in_pay;

  // rdy[k]: slot k may load (it is empty, or everything downstream of it moves).
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = rdy[k+1] || !v[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    decode_pipe_slot #(.W(PW)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .load     (rdy[k]),
      .in_valid (v[k]),
      .in_data  (d[k]),
      .valid    (v[k+1]),
      .data     (d[k+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[STAGES];
  assign out_pay   = d[STAGES];

  assign {op, rs, rt, rd, shamt, funct} = out_pay[PW-1 -: FIELDS_W];
  assign imm_ext = out_pay[PW-FIELDS_W-1 -: DATA_W];

`ifdef DECODE_BRANCH_EN
  assign br_target = out_pay[2*ADDR_W -: ADDR_W];
  assign j_target  = out_pay[ADDR_W:1];
  assign equal     = out_pay[0];
`else
  assign br_target = '0;
  assign j_target  = '0;
  assign equal     = 1'b0;
`endif

endmodule

// File: tb/tb_decode_extend_pipe.sv
// Directed and scoreboard bench for decode_extend_pipe (STAGES=3 main instance,
// STAGES=2 instance for the two-cycle latency vector).
module tb_decode_extend_pipe;

`ifdef DECODE_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, out_ready2;
  logic [31:0] instr, pc_plus4, rs_data, rt_data;
  logic [1:0]  ext_mode;

  logic        in_ready, out_valid, equal;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_ext, br_target, j_target;

  logic        in_ready2, out_valid2, equal2;
  logic [5:0]  op2, funct2;
  logic [4:0]  rs2, rt2, rd2, shamt2;
  logic [31:0] imm_ext2, br_target2, j_target2;

  always #5 clk = ~clk;

  decode_extend_pipe #(.STAGES(3), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_plus4(pc_plus4), .rs_data(rs_data), .rt_data(rt_data),
    .ext_mode(ext_mode), .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm_ext(imm_ext), .br_target(br_target), .j_target(j_target), .equal(equal)
  );

  decode_extend_pipe #(.STAGES(2), .DATA_W(32), .ADDR_W(32)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .instr(instr), .pc_plus4(pc_plus4), .rs_data(rs_data), .rt_data(rt_data),
    .ext_mode(ext_mode), .out_valid(out_valid2), .out_ready(out_ready2),
    .op(op2), .funct(funct2), .rs(rs2), .rt(rt2), .rd(rd2), .shamt(shamt2),
    .imm_ext(imm_ext2), .br_target(br_target2), .j_target(j_target2), .equal(equal2)
  );

  typedef struct packed {
    logic [31:0] fields;
    logic [31:0] imm;
    logic [31:0] br;
    logic [31:0] j;
    logic        eq;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_acc    = 0;
  int           n_out    = 0;
  bit           last_acc;
  bit           hold_pending = 1'b0;
  logic [159:0] held;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, pc, a, b, input logic [1:0] m);
    exp_t        e;
    logic [31:0] sx;
    sx       = {{16{i[15]}}, i[15:0]};
    e.fields = i;
    case (m)
      2'b01:   e.imm = {16'h0000, i[15:0]};
      2'b10:   e.imm = {i[15:0], 16'h0000};
      default: e.imm = sx;
    endcase
    e.br = BR_EN ? pc + (sx << 2) : 32'h0;
    e.j  = BR_EN ? {pc[31:28], i[25:0], 2'b00} : 32'h0;
    e.eq = BR_EN && (a == b);
    return e;
  endfunction

  function automatic logic [159:0] cur_out();
    return {op, rs, rt, rd, shamt, funct, imm_ext, br_target, j_target, equal};
  endfunction

  // Sample 1 time unit before the rising edge, update the scoreboard, return at the next falling edge.
  task automatic tick();
    exp_t         e;
    logic [159:0] cur;
    #4;
    cur      = cur_out();
    last_acc = 1'b0;
    if (reset) begin
      sb_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && out_valid) check("hold_stable", cur, held);
      hold_pending = 1'b0;
      if (out_valid && out_ready) begin
        n_out++;
        check("sb_has_entry", 160'(sb_q.size() != 0), 160'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("sb_fields", {op, rs, rt, rd, shamt, funct}, e.fields);
          check("sb_imm", imm_ext, e.imm);
          check("sb_targets", {br_target, j_target, equal}, {e.br, e.j, e.eq});
        end
      end else if (out_valid && !flush) begin
        hold_pending = 1'b1;
        held         = cur;
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) begin
        sb_q.push_back(model(instr, pc_plus4, rs_data, rt_data, ext_mode));
        n_acc++;
        last_acc = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] i, pc, a, b, input logic [1:0] m);
    instr = i; pc_plus4 = pc; rs_data = a; rt_data = b; ext_mode = m; in_valid = 1'b1;
  endtask

  task automatic drive_rand();
    logic [31:0] a;
    a = $urandom;
    drive($urandom, $urandom, a, ($urandom_range(0, 1) != 0) ? a : $urandom,
          2'($urandom_range(0, 3)));
  endtask

  task automatic send_and_wait(input string tag, input logic [31:0] i, pc, a, b,
                               input logic [1:0] m);
    drive(i, pc, a, b, m);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 12 && !out_valid; k++) tick();
    check({tag, "_arrived"}, 160'(out_valid), 160'd1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (sb_q.size() != 0 || out_valid); k++) tick();
    check("drain_empty", 160'(sb_q.size()), 160'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int snap;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; out_ready2 = 1'b1;
    instr = '0; pc_plus4 = '0; rs_data = '0; rt_data = '0; ext_mode = 2'b00;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", 160'(out_valid), 160'd0);
    check("rst_in_ready", 160'(in_ready), 160'd1);
    check("rst_payload", cur_out(), 160'd0);
    check("rst_out_valid2", 160'(out_valid2), 160'd0);

    // beq through STAGES=2 (2-cycle latency) and STAGES=3
    drive(32'h1085FFFF, 32'h00400008, 32'd7, 32'd7, 2'b00);
    tick();
    in_valid = 1'b0;
    tick();
    check("beq_s2_valid", 160'(out_valid2), 160'd1);
    check("beq_s2_op", 160'(op2), 160'd4);
    check("beq_s2_rs", 160'(rs2), 160'd4);
    check("beq_s2_rt", 160'(rt2), 160'd5);
    check("beq_s2_imm", imm_ext2, 160'hFFFFFFFF);
    check("beq_s2_br", br_target2, BR_EN ? 160'h00400004 : 160'h0);
    check("beq_s2_equal", 160'(equal2), 160'(BR_EN));
    check("beq_s3_not_yet", 160'(out_valid), 160'd0);
    tick();
    check("beq_s3_valid", 160'(out_valid), 160'd1);
    check("beq_s3_br", br_target, BR_EN ? 160'h00400004 : 160'h0);

    // Extension modes
    send_and_wait("ori_zero", 32'h34218000, 32'h00400010, 32'd1, 32'd2, 2'b01);
    check("ori_zero_imm", imm_ext, 160'h00008000);
    check("ori_op", 160'(op), 160'h0D);
    send_and_wait("ori_sign", 32'h34218000, 32'h00400010, 32'd1, 32'd2, 2'b00);
    check("ori_sign_imm", imm_ext, 160'hFFFF8000);
    send_and_wait("ori_mode3", 32'h34218000, 32'h00400010, 32'd1, 32'd2, 2'b11);
    check("ori_mode3_imm", imm_ext, 160'hFFFF8000);
    send_and_wait("lui", 32'h3C011234, 32'h00400014, 32'd0, 32'd0, 2'b10);
    check("lui_imm", imm_ext, 160'h12340000);
    check("lui_rt", 160'(rt), 160'd1);

    // Jump target and branch wrap
    send_and_wait("j", 32'h08100004, 32'h00400008, 32'd3, 32'd9, 2'b00);
    check("j_target", j_target, BR_EN ? 160'h00400010 : 160'h0);
    check("j_br", br_target, BR_EN ? 160'h00400018 : 160'h0);
    check("j_equal", 160'(equal), 160'd0);
    send_and_wait("j_hi", 32'h0BFFFFFF, 32'hA0000000, 32'd5, 32'd5, 2'b00);
    check("j_hi_target", j_target, BR_EN ? 160'hAFFFFFFC : 160'h0);
    send_and_wait("br_wrap", 32'h10000001, 32'hFFFFFFFC, 32'd0, 32'd0, 2'b00);
    check("br_wrap_target", br_target, 160'h0);
    check("br_wrap_equal", 160'(equal), 160'(BR_EN));
    drain();

    // Back-pressure: STAGES=3 holds exactly three beats
    out_ready = 1'b0;
    b = 0;
    for (int k = 0; k < 8; k++) begin
      drive(32'h12345678 ^ (b << 20), 32'h00400000 + 32'(b * 4), 32'(b), 32'd2, 2'(b));
      tick();
      if (last_acc) b++;
    end
    check("bp_accepted", 160'(b), 160'd3);
    check("bp_in_ready_low", 160'(in_ready), 160'd0);
    check("bp_out_valid", 160'(out_valid), 160'd1);
    snap = n_out;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && b < 5; k++) begin
      drive(32'h12345678 ^ (b << 20), 32'h00400000 + 32'(b * 4), 32'(b), 32'd2, 2'(b));
      tick();
      if (last_acc) b++;
    end
    check("bp_all_accepted", 160'(b), 160'd5);
    drain();
    check("bp_all_out", 160'(n_out - snap), 160'd5);

    // Flush with two beats in flight and a beat offered
    drive(32'h20010001, 32'h00400100, 32'd1, 32'd1, 2'b00);
    tick();
    drive(32'h20020002, 32'h00400104, 32'd2, 32'd3, 2'b00);
    tick();
    drive(32'h20030003, 32'h00400108, 32'd4, 32'd4, 2'b00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 160'(out_valid), 160'd0);
    check("flush_in_ready", 160'(in_ready), 160'd1);
    snap = n_out;
    for (int k = 0; k < 5; k++) tick();
    check("flush_no_output", 160'(n_out - snap), 160'd0);
    send_and_wait("post_flush", 32'h3C01ABCD, 32'h00400200, 32'd0, 32'd1, 2'b10);
    check("post_flush_imm", imm_ext, 160'hABCD0000);
    drain();

    // Random traffic, reset mid-stream, then a fresh stream with occasional flush
    for (int k = 0; k < 15; k++) begin
      if ($urandom_range(0, 3) != 0) drive_rand(); else in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b1;
    drive_rand();
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", 160'(out_valid), 160'd0);
    check("midrst_in_ready", 160'(in_ready), 160'd1);
    check("midrst_payload", cur_out(), 160'd0);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) != 0) drive_rand(); else in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
